// File: rtl/fa_chk_pkg.sv
// Shared types and golden full-adder model for the full-adder self-test checker.
package fa_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fa_chk_state_e;

  localparam int NUM_VECTORS = 8;

  // vec = {cin, a, b}; returns {cout, sum}
  function automatic logic [1:0] fa_golden(input logic [2:0] vec);
    logic cin, a, b;
    cin = vec[2];
    a   = vec[1];
    b   = vec[0];
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/fa_golden_model.sv
// Combinational golden full adder: {cin, a, b} in, expected {cout, sum} out.
// Zero latency; no flow control.
module fa_golden_model
  import fa_chk_pkg::*;
(
  input  logic [2:0] vec_i,
  output logic [1:0] exp_o
);

  assign exp_o = fa_golden(vec_i);

endmodule

// File: rtl/fa_selftest_checker.sv
// On-board exhaustive self-test of an external 1-bit full adder; optional per-vector
// fail mask under FA_CHK_FAIL_MASK_EN. Run takes 8*SETTLE_CYCLES cycles; start ignored while busy.
module fa_selftest_checker
  import fa_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       FA_A,
  output logic       FA_B,
  output logic       Cin,
  input  logic       FA_S,
  input  logic       Cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic       fail_valid,
  output logic [2:0] first_fail_vec,
  output logic [7:0] fail_mask
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]    VEC_LAST = 3'(NUM_VECTORS - 1);

  fa_chk_state_e   state_q, state_d;
  logic [2:0]      vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      err_q, err_d;
  logic            fv_q, fv_d;
  logic [2:0]      ffv_q, ffv_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;

  logic [2:0]      stim;
  logic [1:0]      golden;
  logic            mismatch;
  logic            sample;
  logic            start_fire;

  // Stimulus sits at vector 0 outside a run so the adder sees a quiet input.
  assign stim = (state_q == RUN) ? vec_q : 3'd0;
  assign {Cin, FA_A, FA_B} = stim;

  fa_golden_model u_golden (
    .vec_i (stim),
    .exp_o (golden)
  );

  assign mismatch   = ({Cout, FA_S} != golden);
  assign sample     = (state_q == RUN) && (cnt_q == CNT_LAST);
  assign start_fire = start && (state_q != RUN);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ffv_d   = ffv_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          vec_d   = 3'd0;
          cnt_d   = '0;
          err_d   = 4'd0;
          fv_d    = 1'b0;
          ffv_d   = 3'd0;
        end
      end
      RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (mismatch) begin
            err_d = err_q + 4'd1;
            if (!fv_q) begin
              fv_d  = 1'b1;
              ffv_d = vec_q;
            end
          end
          if (vec_q == VEC_LAST) state_d = DONE;
          else                   vec_d   = vec_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
    pass_d = (state_d == DONE) && (err_d == 4'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= '0;
      err_q   <= 4'd0;
      fv_q    <= 1'b0;
      ffv_q   <= 3'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffv_q   <= ffv_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy           = (state_q == RUN);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fv_q;
  assign first_fail_vec = ffv_q;

`ifdef FA_CHK_FAIL_MASK_EN
  logic [7:0] fail_mask_q, fail_mask_d;

  always_comb begin
    fail_mask_d = fail_mask_q;
    if (start_fire)
      fail_mask_d = 8'h00;
    else if (sample && mismatch)
      fail_mask_d[vec_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fail_mask_q <= 8'h00;
    else       fail_mask_q <= fail_mask_d;
  end

  assign fail_mask = fail_mask_q;
`else
  assign fail_mask = 8'h00;
`endif

endmodule

// File: tb/tb_fa_selftest_checker.sv
// Directed bench for fa_selftest_checker: good adder, stuck/inverted faults, reset abort,
// held start, and a SETTLE_CYCLES=1 instance.
module tb_fa_selftest_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       start1 = 1'b0;
  int         mode = 0;

  logic       fa_a, fa_b, cin, fa_s, cout;
  logic       busy, done, pass, fail_valid;
  logic [3:0] err_count;
  logic [2:0] first_fail_vec;
  logic [7:0] fail_mask;

  logic       fa_a1, fa_b1, cin1, fa_s1, cout1;
  logic       busy1, done1, pass1, fail_valid1;
  logic [3:0] err_count1;
  logic [2:0] first_fail_vec1;
  logic [7:0] fail_mask1;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] mask_stuck_exp;
  logic [7:0] mask_inv_exp;

  always #5 clk = ~clk;

  // Model of the external adder with injectable faults: 1 = Cout stuck 0, 2 = sum inverted.
  function automatic logic [1:0] adder(input logic c, input logic a, input logic b, input int m);
    logic s, co;
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    if (m == 1) co = 1'b0;
    if (m == 2) s = ~s;
    return {co, s};
  endfunction

  assign {cout, fa_s}   = adder(cin, fa_a, fa_b, mode);
  assign {cout1, fa_s1} = adder(cin1, fa_a1, fa_b1, 0);

  fa_selftest_checker #(.SETTLE_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start),
    .FA_A(fa_a), .FA_B(fa_b), .Cin(cin), .FA_S(fa_s), .Cout(cout),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .first_fail_vec(first_fail_vec), .fail_mask(fail_mask)
  );

  fa_selftest_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .FA_A(fa_a1), .FA_B(fa_b1), .Cin(cin1), .FA_S(fa_s1), .Cout(cout1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
    .fail_valid(fail_valid1), .first_fail_vec(first_fail_vec1), .fail_mask(fail_mask1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef FA_CHK_FAIL_MASK_EN
    mask_stuck_exp = 8'hE8;
    mask_inv_exp   = 8'hFF;
`else
    mask_stuck_exp = 8'h00;
    mask_inv_exp   = 8'h00;
`endif

    // Reset state
    #3;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_pass", {7'd0, pass}, 8'd0);
    chk("rst_err", {4'd0, err_count}, 8'd0);
    chk("rst_fv", {7'd0, fail_valid}, 8'd0);
    chk("rst_ffv", {5'd0, first_fail_vec}, 8'd0);
    chk("rst_mask", fail_mask, 8'h00);
    chk("rst_stim", {5'd0, cin, fa_a, fa_b}, 8'd0);
    #9 reset = 1'b0;

    // Good adder: done exactly 80 edges after start
    start = 1'b1; tick(1); start = 1'b0;
    chk("good_busy0", {7'd0, busy}, 8'd1);
    chk("good_stim0", {5'd0, cin, fa_a, fa_b}, 8'd0);
    tick(9);
    chk("good_stim0_hold", {5'd0, cin, fa_a, fa_b}, 8'd0);
    tick(1);
    chk("good_stim1", {5'd0, cin, fa_a, fa_b}, 8'd1);
    tick(69);
    chk("good_done_early", {7'd0, done}, 8'd0);
    chk("good_busy_late", {7'd0, busy}, 8'd1);
    tick(1);
    chk("good_done", {7'd0, done}, 8'd1);
    chk("good_pass", {7'd0, pass}, 8'd1);
    chk("good_busy_end", {7'd0, busy}, 8'd0);
    chk("good_err", {4'd0, err_count}, 8'd0);
    chk("good_fv", {7'd0, fail_valid}, 8'd0);
    chk("good_mask", fail_mask, 8'h00);
    chk("good_stim_end", {5'd0, cin, fa_a, fa_b}, 8'd0);

    // Cout stuck at 0: vectors 3,5,6,7 fail
    mode = 1;
    start = 1'b1; tick(1); start = 1'b0;
    tick(80);
    chk("stuck_done", {7'd0, done}, 8'd1);
    chk("stuck_pass", {7'd0, pass}, 8'd0);
    chk("stuck_err", {4'd0, err_count}, 8'd4);
    chk("stuck_fv", {7'd0, fail_valid}, 8'd1);
    chk("stuck_ffv", {5'd0, first_fail_vec}, 8'd3);
    chk("stuck_mask", fail_mask, mask_stuck_exp);

    // Sum inverted: all vectors fail
    mode = 2;
    start = 1'b1; tick(1); start = 1'b0;
    chk("inv_cleared_err", {4'd0, err_count}, 8'd0);
    chk("inv_done_cleared", {7'd0, done}, 8'd0);
    tick(80);
    chk("inv_err", {4'd0, err_count}, 8'd8);
    chk("inv_ffv", {5'd0, first_fail_vec}, 8'd0);
    chk("inv_pass", {7'd0, pass}, 8'd0);
    chk("inv_mask", fail_mask, mask_inv_exp);

    // Reset while vector 4 is driven (stuck fault so vector 3 has already failed)
    mode = 1;
    start = 1'b1; tick(1); start = 1'b0;
    tick(40);
    chk("abort_stim4", {5'd0, cin, fa_a, fa_b}, 8'b100);
    chk("abort_err_pre", {4'd0, err_count}, 8'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_stim", {5'd0, cin, fa_a, fa_b}, 8'd0);
    chk("abort_err", {4'd0, err_count}, 8'd0);
    chk("abort_fv", {7'd0, fail_valid}, 8'd0);
    chk("abort_ffv", {5'd0, first_fail_vec}, 8'd0);
    chk("abort_done", {7'd0, done}, 8'd0);
    chk("abort_mask", fail_mask, 8'h00);
    #3 reset = 1'b0;
    mode = 0;
    start = 1'b1; tick(1); start = 1'b0;
    tick(80);
    chk("after_abort_done", {7'd0, done}, 8'd1);
    chk("after_abort_pass", {7'd0, pass}, 8'd1);

    // start held high: no restart in RUN, restart on edge after DONE
    mode = 1;
    start = 1'b1; tick(1);
    tick(40);
    chk("held_busy", {7'd0, busy}, 8'd1);
    chk("held_stim4", {5'd0, cin, fa_a, fa_b}, 8'b100);
    tick(40);
    chk("held_done", {7'd0, done}, 8'd1);
    chk("held_err", {4'd0, err_count}, 8'd4);
    tick(1);
    chk("held_restart_busy", {7'd0, busy}, 8'd1);
    chk("held_restart_done", {7'd0, done}, 8'd0);
    chk("held_restart_err", {4'd0, err_count}, 8'd0);
    chk("held_restart_fv", {7'd0, fail_valid}, 8'd0);
    chk("held_restart_mask", fail_mask, 8'h00);
    start = 1'b0;
    mode = 0;
    tick(79);
    chk("held_run2_busy", {7'd0, busy}, 8'd1);
    tick(1);
    chk("held_run2_done", {7'd0, done}, 8'd1);
    chk("held_run2_pass", {7'd0, pass}, 8'd1);

    // SETTLE_CYCLES = 1: done exactly 8 edges after start
    start1 = 1'b1; tick(1); start1 = 1'b0;
    chk("s1_busy", {7'd0, busy1}, 8'd1);
    tick(1);
    chk("s1_stim1", {5'd0, cin1, fa_a1, fa_b1}, 8'd1);
    tick(6);
    chk("s1_done_early", {7'd0, done1}, 8'd0);
    tick(1);
    chk("s1_done", {7'd0, done1}, 8'd1);
    chk("s1_pass", {7'd0, pass1}, 8'd1);
    chk("s1_err", {4'd0, err_count1}, 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
